// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundles the fetch, data and memory-side signals of
//               mem_port_arbiter.
//               slave  - the arbiter's view (drives gnt/rvalid/rdata/mem_*)
//               master - the environment's view (drives requests, mem_ack)
// Ports       : if_*  fetch requester handshake
//               d_*   load/store requester handshake
//               mem_* single-port memory command / response
//               err   abort pulse, busy  arbiter not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  // Data requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              err;
  // Memory side
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
           mem_ack, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
           mem_ack, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port memory between instruction fetch and
//               load/store. One transaction in flight; data has priority,
//               but after MAX_D_STREAK consecutive data grants with fetch
//               waiting, fetch is served next. Each transaction is aborted
//               (err pulse, rdata = 0) if mem_ack does not arrive within
//               TIMEOUT busy cycles.
// Ports       : clk  - clock
//               rst  - synchronous reset, active low
//               bus  - mem_port_arbiter_if.slave (requesters + memory)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 16
) (
  input  wire logic               clk,
  input  wire logic               rst,
  mem_port_arbiter_if.slave       bus
);

  localparam int c_STK_W = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam int c_TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_STK_W-1:0] c_STK_MAX = c_STK_W'(MAX_D_STREAK);
  localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY_IF = 2'd1,
    S_BUSY_D  = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_STK_W-1:0]  r_streak;
  logic [c_TMO_W-1:0]  r_tmo;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [3:0]          r_mem_be;
  logic                r_if_rvalid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic                r_d_rvalid;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_err;

  logic                w_idle;
  logic                w_sel_d;
  logic                w_sel_if;
  logic                w_tmo_hit;

  // Data wins unless fetch is waiting and data has used up its streak.
  assign w_idle    = (r_state == S_IDLE);
  assign w_sel_d   = w_idle && bus.d_req && !(bus.if_req && (r_streak == c_STK_MAX));
  assign w_sel_if  = w_idle && !w_sel_d && bus.if_req;
  assign w_tmo_hit = (r_tmo == c_TMO_MAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_streak    <= '0;
      r_tmo       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= 4'h0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= '0;
      r_err       <= 1'b0;
    end else begin
      // Response strobes are single-cycle pulses.
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_err       <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_tmo <= '0;
          if (w_sel_d) begin
            r_state     <= S_BUSY_D;
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.d_we;
            r_mem_addr  <= bus.d_addr;
            r_mem_wdata <= bus.d_wdata;
            r_mem_be    <= bus.d_be;
            if (!bus.if_req)
              r_streak <= '0;
            else if (r_streak != c_STK_MAX)
              r_streak <= r_streak + 1'b1;
          end else if (w_sel_if) begin
            r_state     <= S_BUSY_IF;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= bus.if_addr;
            r_mem_be    <= 4'hF;
            r_streak    <= '0;
          end
        end

        S_BUSY_IF, S_BUSY_D: begin
          // An ack on the last allowed cycle still counts as success.
          if (bus.mem_ack || w_tmo_hit) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
            r_tmo     <= '0;
            r_err     <= !bus.mem_ack;
            if (r_state == S_BUSY_IF) begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= bus.mem_ack ? bus.mem_rdata : '0;
            end else begin
              r_d_rvalid <= 1'b1;
              r_d_rdata  <= (bus.mem_ack && !r_mem_we) ? bus.mem_rdata : '0;
            end
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
          r_tmo     <= '0;
        end
      endcase
    end
  end

  assign bus.if_gnt    = w_sel_if;
  assign bus.d_gnt     = w_sel_d;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rvalid  = r_d_rvalid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.err       = r_err;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;
  assign bus.busy      = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter. Inputs
//               change 1 ns after the rising edge; outputs are sampled then.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4), .TIMEOUT(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    logic exp_if;
    logic [9:0] gnt_seq;

    mif.if_req = 0; mif.if_addr = '0;
    mif.d_req = 0; mif.d_we = 0; mif.d_addr = '0; mif.d_wdata = '0; mif.d_be = '0;
    mif.mem_ack = 0; mif.mem_rdata = '0;

    // ---- Reset ----
    rst = 0;
    tick(); tick();
    chk("rst_mem_req", 32'(mif.mem_req), 0);
    chk("rst_busy", 32'(mif.busy), 0);
    chk("rst_if_rvalid", 32'(mif.if_rvalid), 0);
    chk("rst_d_rvalid", 32'(mif.d_rvalid), 0);
    chk("rst_err", 32'(mif.err), 0);
    chk("rst_if_rdata", mif.if_rdata, 0);
    chk("rst_d_rdata", mif.d_rdata, 0);
    chk("rst_mem_addr", mif.mem_addr, 0);
    rst = 1;
    tick();

    // ---- Single fetch, zero-wait ack ----
    mif.if_req = 1; mif.if_addr = 32'h10;
    #1;
    chk("f_if_gnt", 32'(mif.if_gnt), 1);
    chk("f_d_gnt", 32'(mif.d_gnt), 0);
    tick();
    mif.if_req = 0;
    chk("f_mem_req", 32'(mif.mem_req), 1);
    chk("f_mem_addr", mif.mem_addr, 32'h10);
    chk("f_mem_be", 32'(mif.mem_be), 32'hF);
    chk("f_mem_we", 32'(mif.mem_we), 0);
    chk("f_busy1", 32'(mif.busy), 1);
    chk("f_gnt_busy", 32'(mif.if_gnt), 0);
    mif.mem_ack = 1; mif.mem_rdata = 32'h00500093;
    tick();
    mif.mem_ack = 0;
    chk("f_if_rvalid", 32'(mif.if_rvalid), 1);
    chk("f_if_rdata", mif.if_rdata, 32'h00500093);
    chk("f_busy2", 32'(mif.busy), 0);
    chk("f_mem_req_low", 32'(mif.mem_req), 0);
    chk("f_d_rvalid", 32'(mif.d_rvalid), 0);
    tick();
    chk("f_rvalid_pulse", 32'(mif.if_rvalid), 0);
    chk("f_rdata_hold", mif.if_rdata, 32'h00500093);

    // ---- mem_ack while idle is ignored ----
    mif.mem_ack = 1; mif.mem_rdata = 32'h55;
    tick();
    mif.mem_ack = 0;
    chk("idle_ack_if", 32'(mif.if_rvalid), 0);
    chk("idle_ack_d", 32'(mif.d_rvalid), 0);
    chk("idle_ack_busy", 32'(mif.busy), 0);

    // ---- Store, 3 wait cycles ----
    mif.d_req = 1; mif.d_we = 1; mif.d_addr = 32'h40;
    mif.d_wdata = 32'hDEADBEEF; mif.d_be = 4'b0011;
    #1;
    chk("s_d_gnt", 32'(mif.d_gnt), 1);
    tick();
    mif.d_req = 0;
    for (int i = 0; i < 4; i++) begin
      chk("s_mem_req", 32'(mif.mem_req), 1);
      chk("s_mem_we", 32'(mif.mem_we), 1);
      chk("s_mem_wdata", mif.mem_wdata, 32'hDEADBEEF);
      chk("s_mem_addr", mif.mem_addr, 32'h40);
      chk("s_mem_be", 32'(mif.mem_be), 32'h3);
      if (i < 3) tick();
    end
    mif.mem_ack = 1; mif.mem_rdata = 32'hFFFFFFFF;
    tick();
    mif.mem_ack = 0;
    chk("s_d_rvalid", 32'(mif.d_rvalid), 1);
    chk("s_d_rdata", mif.d_rdata, 0);
    chk("s_err", 32'(mif.err), 0);
    chk("s_if_rvalid", 32'(mif.if_rvalid), 0);
    tick();

    // ---- Contention: D,D,D,D,IF,D,D,D,D,IF (bit i = 1 means fetch) ----
    gnt_seq = 10'b10000_10000;
    mif.d_we = 0; mif.d_addr = 32'h80; mif.if_addr = 32'h20;
    mif.if_req = 1; mif.d_req = 1;
    for (int i = 0; i < 10; i++) begin
      exp_if = gnt_seq[i];
      #1;
      chk("c_if_gnt", 32'(mif.if_gnt), 32'(exp_if));
      chk("c_d_gnt", 32'(mif.d_gnt), 32'(!exp_if));
      tick();
      mif.mem_ack = 1; mif.mem_rdata = 32'(i + 1);
      tick();
      mif.mem_ack = 0;
      chk("c_if_rvalid", 32'(mif.if_rvalid), 32'(exp_if));
      chk("c_d_rvalid", 32'(mif.d_rvalid), 32'(!exp_if));
    end
    mif.if_req = 0; mif.d_req = 0;
    chk("c_if_rdata", mif.if_rdata, 32'd10);
    chk("c_d_rdata", mif.d_rdata, 32'd9);
    tick();

    // ---- Timeout: load never acked ----
    mif.d_req = 1; mif.d_we = 0; mif.d_addr = 32'h84;
    #1;
    chk("t_d_gnt", 32'(mif.d_gnt), 1);
    tick();
    mif.d_req = 0;
    n = 0;
    while (mif.mem_req && n < 40) begin
      n++;
      tick();
    end
    chk("t_mem_req_cycles", 32'(n), 16);
    chk("t_d_rvalid", 32'(mif.d_rvalid), 1);
    chk("t_err", 32'(mif.err), 1);
    chk("t_d_rdata", mif.d_rdata, 0);
    chk("t_busy", 32'(mif.busy), 0);
    chk("t_if_rvalid", 32'(mif.if_rvalid), 0);
    tick();
    chk("t_err_pulse", 32'(mif.err), 0);
    chk("t_rvalid_pulse", 32'(mif.d_rvalid), 0);

    // ---- Ack in the 16th busy cycle is a success ----
    mif.d_req = 1; mif.d_addr = 32'h88;
    #1;
    chk("b_d_gnt", 32'(mif.d_gnt), 1);
    tick();
    mif.d_req = 0;
    repeat (15) tick();
    chk("b_mem_req16", 32'(mif.mem_req), 1);
    mif.mem_ack = 1; mif.mem_rdata = 32'h1234;
    tick();
    mif.mem_ack = 0;
    chk("b_d_rvalid", 32'(mif.d_rvalid), 1);
    chk("b_err", 32'(mif.err), 0);
    chk("b_d_rdata", mif.d_rdata, 32'h1234);
    tick();

    // ---- Reset during a fetch ----
    mif.if_req = 1; mif.if_addr = 32'h20;
    #1;
    chk("r_if_gnt", 32'(mif.if_gnt), 1);
    tick();
    mif.if_req = 0;
    chk("r_busy_before", 32'(mif.busy), 1);
    rst = 0;
    tick();
    rst = 1;
    chk("r_mem_req", 32'(mif.mem_req), 0);
    chk("r_busy", 32'(mif.busy), 0);
    chk("r_if_rvalid", 32'(mif.if_rvalid), 0);
    chk("r_mem_addr", mif.mem_addr, 0);
    tick();
    chk("r_if_rvalid2", 32'(mif.if_rvalid), 0);
    mif.if_req = 1; mif.if_addr = 32'h24;
    #1;
    chk("r2_if_gnt", 32'(mif.if_gnt), 1);
    tick();
    mif.if_req = 0;
    chk("r2_mem_addr", mif.mem_addr, 32'h24);
    mif.mem_ack = 1; mif.mem_rdata = 32'h0000CAFE;
    tick();
    mif.mem_ack = 0;
    chk("r2_if_rvalid", 32'(mif.if_rvalid), 1);
    chk("r2_if_rdata", mif.if_rdata, 32'h0000CAFE);
    chk("r2_err", 32'(mif.err), 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the instruction-fetch path and the load/store data path of the RV32I core.
The block accepts one request at a time from either requester. It issues that request to memory, waits for the memory acknowledge (with a timeout), and returns the read data or write completion to the requester that owns the transaction.
Data accesses have priority. A streak limit guarantees that fetch makes forward progress.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_D_STREAK, 4, maximum consecutive data grants while if_req is pending; the next grant then goes to fetch
TIMEOUT, 16, cycles to wait for mem_ack before aborting the transaction

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  fetched instruction
d_req  in  1  data request; held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_be  in  4  byte enables
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  one-cycle pulse: load data valid or store complete
d_rdata  out  DATA_W  load data; 0 for stores
err  out  1  one-cycle pulse, coincident with the rvalid of an aborted transaction
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  4  memory byte enables; 4'hF for fetches
mem_ack  in  1  memory has completed the request this cycle
mem_rdata  in  DATA_W  read data, valid with mem_ack
busy  out  1  1 when state is not IDLE

Behaviour:
- Reset (rst == 0 at a clk edge): state goes to IDLE and the streak counter and timeout counter go to 0. All registered outputs go to 0: mem_*, *_rvalid, *_rdata, err. Reset during a transaction drops it; no rvalid is issued and mem_req is low the cycle after the edge.
- States: IDLE, BUSY_IF, BUSY_D.
- IDLE, selection (combinational):
  - If d_req and not (if_req and streak == MAX_D_STREAK), select data.
  - Otherwise, if if_req, select fetch.
  - Otherwise, no selection.
- The selected requester's gnt is high in that same cycle; gnt is 0 outside IDLE.
- At the gnt edge, the command is latched into the mem_* registers. mem_we/mem_be come from d_we/d_be for data, and are 0/4'hF for fetch. State moves to BUSY_D or BUSY_IF.
- Streak counter:
  - Increments on a data grant while if_req == 1, saturating at MAX_D_STREAK.
  - Clears on a fetch grant.
  - Clears on a data grant while if_req == 0.
- BUSY_*:
  - mem_req is 1 and the mem_* command is held stable.
  - The timeout counter increments each cycle without mem_ack.
  - On mem_ack: capture mem_rdata (0 if the transaction is a store) into the owner's rdata, pulse the owner's rvalid in the next cycle, drop mem_req, and return to IDLE.
  - If the counter reaches TIMEOUT-1 without mem_ack: abort. Pulse the owner's rvalid and err next cycle with rdata = 0, and return to IDLE.
  - mem_ack in the same cycle as timeout expiry counts as success; err stays 0.
  - The timeout counter clears on entry to IDLE.
- Latency: gnt at cycle t, mem_req in t+1. With a zero-wait ack in t+1, rvalid is in t+2. A new gnt may be issued in t+2 (the rvalid cycle). Peak rate is one access per 2 cycles.
- mem_ack while in IDLE is ignored.
- rdata holds its last value between pulses.
- The non-owner's rvalid is never asserted.
- Requests that drop before gnt are never granted.

Test Plan:
- Single fetch: if_req=1, if_addr=0x10; memory acks 1 cycle after mem_req with 0x00500093 -> if_gnt at t0; mem_req=1, mem_addr=0x10, mem_be=F at t1; if_rvalid=1 with if_rdata=0x00500093 at t2; busy=0 at t2.
- Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_be=4'b0011; ack after 3 wait cycles -> mem_we=1 and mem_wdata=0xDEADBEEF held for 4 cycles; d_rvalid pulse with d_rdata=0.
- Contention: if_req and d_req both held high, zero-wait memory, MAX_D_STREAK=4 -> grant sequence D,D,D,D,IF,D,D,D,D,IF.
- Timeout: d_req load, mem_ack never arrives, TIMEOUT=16 -> mem_req high exactly 16 cycles; then d_rvalid=1, err=1, d_rdata=0 for one cycle; back to IDLE.
- Ack on the timeout boundary: mem_ack arrives in the 16th busy cycle with 0x1234 -> d_rvalid=1, err=0, d_rdata=0x1234.
- Reset mid-transaction: rst=0 during BUSY_IF -> next cycle mem_req=0, busy=0, no if_rvalid; after release, a new fetch completes normally.
